lif_spike_encoder: RTL and testbench
====================================

// Module: lif_spike_encoder
// PURPOSE
//   Downstream of SystolicController: consumes linear-layer partial sums (o_PsumData/o_PsumValid,
//   one neuron per beat, T_STEPS time steps packed, t0 in LSBs) and runs a multi-step LIF neuron.
//   Packs the resulting spikes into OUT_W-bit words and streams them to the next stage.
//   The stream is valid/ready; o_done is issued after o_Psum_Finish once the last word drains.
// PARAMETERS
//   PSUM_W      20   signed width of one time-step psum (SYSTOLIC_PSUM_WIDTH / T_STEPS)
//   T_STEPS     4    time steps per beat; one pipeline stage per step
//   VTH         256  firing threshold, signed, same scale as psum
//   OUT_W       64   output word width; NPW = OUT_W/T_STEPS = 16 neurons per word
//   FIFO_DEPTH  4    output word FIFO depth (power of 2)
// PORTS
//   s_clk          in   1               clock
//   s_rst_n        in   1               asynchronous, active-low reset
//   i_PsumData     in   T_STEPS*PSUM_W  psums, step t at [t*PSUM_W +: PSUM_W], signed
//   i_PsumValid    in   1               beat valid; no backpressure upstream
//   i_Psum_Finish  in   1               1-cycle pulse: last beat of layer already sent (or same cycle)
//   o_spike_data   out  OUT_W           neuron n of word at [n*T_STEPS +: T_STEPS], bit t = step t
//   o_spike_valid  out  1               FIFO head valid
//   i_spike_ready  in   1               downstream accept; transfer = valid & ready
//   o_spike_last   out  1               marks final word of layer, qualified by o_spike_valid
//   o_done         out  1               1-cycle pulse after last word transferred
//   o_overflow     out  1               sticky: a completed word was dropped (FIFO full)
// BEHAVIOUR
//   Reset (async, s_rst_n=0): all outputs 0, pipeline/packer/FIFO empty, state IDLE, overflow cleared.
//   LIF per beat, V0=0, width PSUM_W+2 signed, >>> arithmetic (floor):
//     H_t = V_{t-1} + ((X_t - V_{t-1}) >>> 1);  S_t = (H_t >= VTH);  V_t = S_t ? Vres : H_t.
//   Pipeline: stage t computes step t; spike vector registered at cycle c+T_STEPS for beat at c.
//     Fully pipelined, 1 beat/cycle; membrane does not carry between beats (each beat = new neuron).
//   Packer: neuron slot counter 0..NPW-1; slot NPW-1 filled -> word pushed to FIFO next cycle,
//     counter wraps to 0. Unused slots are 0.
//   FIFO full at push: word dropped, o_overflow <= 1 (sticky until reset); packer continues.
//   Simultaneous push and pop on full FIFO: pop frees slot, push accepted, no overflow.
//   FSM: IDLE -> RUN on first i_PsumValid. RUN -> DRAIN on i_Psum_Finish (a valid beat in the same
//     cycle is included). DRAIN: wait T_STEPS cycles for pipeline empty, then flush a partial word
//     (slot counter != 0) zero-padded; final pushed word gets last flag. If the layer ended exactly on
//     a word boundary, the already-pushed final word's flag is set via a last-pending register.
//     DRAIN -> WAIT_OUT; WAIT_OUT -> IDLE when the last-flagged word transfers, o_done=1 that cycle+1.
//   Finish with zero beats since IDLE: no word, o_done pulses T_STEPS+2 cycles after finish.
//   i_PsumValid in DRAIN/WAIT_OUT: ignored (protocol error), no state change.
//   o_spike_data/o_spike_last hold stable while valid & !ready.
// CONFIGURATION
//   LIF_SOFT_RESET_EN defined: Vres = H_t - VTH (soft reset, subtract threshold).
//   LIF_SOFT_RESET_EN undefined (default): Vres = 0 (hard reset, Spikformer v_reset=0).
// TESTING
//   1 beat all X=512, finish, ready=1 -> one word, neuron0 = 4'b1111, rest 0, last=1, o_done pulse.
//   1 beat all X=300 -> H = 150,225,262,... -> neuron0 = 4'b0100 (both reset modes; soft V2=6).
//   1 beat all X=-1000 -> 4'b0000; H saturation-free, no spurious spike from sign wrap.
//   40 beats X=512 + finish -> 3 words; words 0,1 = all 1s; word 2 low 32 bits 1s, high 32 = 0, last=1.
//   32 beats then finish (word boundary) -> exactly 2 words, last flag on word 2, no empty word.
//   i_spike_ready=0 for 100 beats X=512 -> 4 words queued, 5th dropped, o_overflow=1 and stays 1;
//     async reset asserted mid-stream -> all outputs 0 immediately, overflow cleared.

Source files
------------

// File: rtl/lif_spike_encoder.sv
// rtl/lif_spike_encoder.sv - pipelined multi-step LIF neuron, spike word packer and output FIFO
// Define LIF_SOFT_RESET_EN for subtract-threshold membrane reset; default is hard reset to zero.
module lif_spike_encoder #(
    parameter int PSUM_W     = 20,
    parameter int T_STEPS    = 4,
    parameter int VTH        = 256,
    parameter int OUT_W      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       s_clk,
    input  logic                       s_rst_n,
    input  logic [T_STEPS*PSUM_W-1:0]  i_PsumData,
    input  logic                       i_PsumValid,
    input  logic                       i_Psum_Finish,
    output logic [OUT_W-1:0]           o_spike_data,
    output logic                       o_spike_valid,
    input  logic                       i_spike_ready,
    output logic                       o_spike_last,
    output logic                       o_done,
    output logic                       o_overflow
);
    localparam int NPW    = OUT_W / T_STEPS;
    localparam int VW     = PSUM_W + 2;
    localparam int SLOT_W = $clog2(NPW);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(T_STEPS + 2);
    localparam logic signed [VW-1:0] VTH_S = VW'(VTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT_OUT} state_t;

    state_t state, nextState;
    logic [CNT_W-1:0] drainCnt;
    logic beatSeen;
    logic acceptBeat, flushNow, doneSet;

    logic                        pipeValid [0:T_STEPS];
    logic [T_STEPS-1:0]          pipeS     [0:T_STEPS];
    logic [T_STEPS*PSUM_W-1:0]   pipeX     [0:T_STEPS-1];
    logic signed [VW-1:0]        pipeV     [0:T_STEPS-1];

    logic signed [PSUM_W-1:0]    stepXn [0:T_STEPS-1];
    logic signed [VW-1:0]        stepX  [0:T_STEPS-1];
    logic signed [VW-1:0]        stepH  [0:T_STEPS-1];
    logic signed [VW-1:0]        stepV  [0:T_STEPS-1];
    logic                        stepS  [0:T_STEPS-1];

    logic [SLOT_W-1:0] slot;
    logic [OUT_W-1:0]  packWord, pushWord;
    logic              pushValid, pushLast, pushLastEff, markLast, markOld;

    logic [OUT_W-1:0]  dataMem [0:FIFO_DEPTH-1];
    logic              lastMem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [PTR_W:0]    fifoCount;
    logic              fifoFull, fifoPop, fifoWrite;

    assign acceptBeat = (state == IDLE) || (state == RUN);

    // One LIF step per stage; the membrane is widened by two bits so the halving never wraps.
    always_comb begin
        for (int t = 0; t < T_STEPS; t++) begin
            stepXn[t] = pipeX[t][t*PSUM_W +: PSUM_W];
            stepX[t]  = VW'(stepXn[t]);
            stepH[t]  = pipeV[t] + ((stepX[t] - pipeV[t]) >>> 1);
            stepS[t]  = (stepH[t] >= VTH_S);
`ifdef LIF_SOFT_RESET_EN
            stepV[t]  = stepS[t] ? (stepH[t] - VTH_S) : stepH[t];
`else
            stepV[t]  = stepS[t] ? '0 : stepH[t];
`endif
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int t = 0; t <= T_STEPS; t++) begin
                pipeValid[t] <= 1'b0;
                pipeS[t]     <= '0;
            end
            for (int t = 0; t < T_STEPS; t++) begin
                pipeX[t] <= '0;
                pipeV[t] <= '0;
            end
        end else begin
            pipeValid[0] <= i_PsumValid && acceptBeat;
            pipeX[0]     <= i_PsumData;
            pipeV[0]     <= '0;
            pipeS[0]     <= '0;
            for (int t = 1; t < T_STEPS; t++) begin
                pipeX[t] <= pipeX[t-1];
                pipeV[t] <= stepV[t-1];
            end
            for (int t = 0; t < T_STEPS; t++) begin
                pipeValid[t+1] <= pipeValid[t];
                pipeS[t+1]     <= pipeS[t] | (T_STEPS'(stepS[t]) << t);
            end
        end
    end

    always_comb begin
        nextState = state;
        flushNow  = 1'b0;
        doneSet   = 1'b0;
        case (state)
            IDLE: begin
                if (i_Psum_Finish)    nextState = DRAIN;
                else if (i_PsumValid) nextState = RUN;
            end
            RUN: begin
                if (i_Psum_Finish) nextState = DRAIN;
            end
            DRAIN: begin
                // One extra cycle with beats lets the packer absorb the final spike vector.
                if (!beatSeen && drainCnt == CNT_W'(T_STEPS)) begin
                    nextState = IDLE;
                    doneSet   = 1'b1;
                end else if (beatSeen && drainCnt == CNT_W'(T_STEPS + 1)) begin
                    nextState = WAIT_OUT;
                    flushNow  = 1'b1;
                end
            end
            WAIT_OUT: begin
                // Emptying without a flagged word covers a final word lost to overflow.
                if ((fifoPop && o_spike_last) || (fifoCount == '0 && !pushValid)) begin
                    nextState = IDLE;
                    doneSet   = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= IDLE;
            drainCnt <= '0;
            beatSeen <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= nextState;
            o_done   <= doneSet;
            drainCnt <= (state == DRAIN) ? drainCnt + 1'b1 : '0;
            if (state != IDLE && nextState == IDLE)
                beatSeen <= 1'b0;
            else if (acceptBeat && i_PsumValid)
                beatSeen <= 1'b1;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            slot      <= '0;
            packWord  <= '0;
            pushWord  <= '0;
            pushValid <= 1'b0;
            pushLast  <= 1'b0;
        end else begin
            pushValid <= 1'b0;
            pushLast  <= 1'b0;
            if (pipeValid[T_STEPS]) begin
                if (slot == SLOT_W'(NPW - 1)) begin
                    pushWord  <= packWord | (OUT_W'(pipeS[T_STEPS]) << (slot * T_STEPS));
                    pushValid <= 1'b1;
                    packWord  <= '0;
                    slot      <= '0;
                end else begin
                    packWord[slot*T_STEPS +: T_STEPS] <= pipeS[T_STEPS];
                    slot <= slot + 1'b1;
                end
            end else if (flushNow && slot != '0) begin
                pushWord  <= packWord;
                pushValid <= 1'b1;
                pushLast  <= 1'b1;
                packWord  <= '0;
                slot      <= '0;
            end
        end
    end

    // Layer ended on a word boundary: tag the newest word, whether in flight or already queued.
    assign markLast    = flushNow && (slot == '0);
    assign pushLastEff = pushLast || (markLast && pushValid);
    assign markOld     = markLast && !pushValid && (fifoCount != '0);

    assign fifoFull      = (fifoCount == (PTR_W+1)'(FIFO_DEPTH));
    assign fifoPop       = o_spike_valid && i_spike_ready;
    assign fifoWrite     = pushValid && (!fifoFull || fifoPop);
    assign o_spike_valid = (fifoCount != '0);
    assign o_spike_data  = o_spike_valid ? dataMem[rdPtr] : '0;
    assign o_spike_last  = o_spike_valid && lastMem[rdPtr];

    always_ff @(posedge s_clk) begin
        if (fifoWrite) begin
            dataMem[wrPtr] <= pushWord;
            lastMem[wrPtr] <= pushLastEff;
        end else if (markOld) begin
            lastMem[wrPtr - 1'b1] <= 1'b1;
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            fifoCount  <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (fifoWrite) wrPtr <= wrPtr + 1'b1;
            if (fifoPop)   rdPtr <= rdPtr + 1'b1;
            if (fifoWrite && !fifoPop)      fifoCount <= fifoCount + 1'b1;
            else if (!fifoWrite && fifoPop) fifoCount <= fifoCount - 1'b1;
            if (pushValid && fifoFull && !fifoPop) o_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lif_spike_encoder.sv
// tb/tb_lif_spike_encoder.sv - self-checking bench for lif_spike_encoder
module tb_lif_spike_encoder;
    localparam int PSUM_W = 20;
    localparam int T      = 4;
    localparam int OUT_W  = 64;
    localparam int NPW    = OUT_W / T;
    localparam int VTH    = 256;

    typedef int xv_t [T];
    typedef struct {
        int         n;
        int         x;
        int         finDelay;
        int         strayAt;
        int         expWords;
        logic [3:0] expNib;
    } vec_t;

    logic                  s_clk = 1'b0;
    logic                  s_rst_n;
    logic [T*PSUM_W-1:0]   i_PsumData;
    logic                  i_PsumValid;
    logic                  i_Psum_Finish;
    logic [OUT_W-1:0]      o_spike_data;
    logic                  o_spike_valid;
    logic                  i_spike_ready;
    logic                  o_spike_last;
    logic                  o_done;
    logic                  o_overflow;

    int          nChecks = 0;
    int          nFails  = 0;
    int          doneCnt = 0;
    logic [63:0] gotData[$];
    bit          gotLast[$];
    xv_t         layerX[$];
    bit          randReady  = 1'b0;
    bit          readyLevel = 1'b0;
    bit          prevStall  = 1'b0;
    logic [63:0] prevData   = '0;
    vec_t        vecs [7];

    lif_spike_encoder #(
        .PSUM_W(PSUM_W), .T_STEPS(T), .VTH(VTH), .OUT_W(OUT_W), .FIFO_DEPTH(4)
    ) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .i_PsumData(i_PsumData), .i_PsumValid(i_PsumValid),
        .i_Psum_Finish(i_Psum_Finish), .o_spike_data(o_spike_data), .o_spike_valid(o_spike_valid),
        .i_spike_ready(i_spike_ready), .o_spike_last(o_spike_last), .o_done(o_done),
        .o_overflow(o_overflow)
    );

    always #5 s_clk = ~s_clk;

    always @(posedge s_clk) begin
        #1;
        i_spike_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge s_clk) begin
        if (!s_rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && o_spike_valid) check("hold_data", o_spike_data, prevData);
            if (o_spike_valid && i_spike_ready) begin
                gotData.push_back(o_spike_data);
                gotLast.push_back(o_spike_last);
            end
            prevStall = o_spike_valid && !i_spike_ready;
            prevData  = o_spike_data;
            if (o_done) doneCnt++;
        end
    end

    function automatic logic [3:0] lif_ref(input xv_t x);
        int v = 0;
        int h;
        logic [3:0] s = '0;
        for (int t = 0; t < T; t++) begin
            h = v + ((x[t] - v) >>> 1);
            if (h >= VTH) begin
                s[t] = 1'b1;
`ifdef LIF_SOFT_RESET_EN
                v = h - VTH;
`else
                v = 0;
`endif
            end else begin
                v = h;
            end
        end
        return s;
    endfunction

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic drive_beat(input xv_t x, input bit fin);
        i_PsumValid = 1'b1;
        for (int t = 0; t < T; t++) i_PsumData[t*PSUM_W +: PSUM_W] = PSUM_W'(x[t]);
        i_Psum_Finish = fin;
        step();
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
    endtask

    task automatic do_reset();
        s_rst_n       = 1'b0;
        i_PsumValid   = 1'b0;
        i_Psum_Finish = 1'b0;
        i_PsumData    = '0;
        repeat (3) @(posedge s_clk);
        #1;
    endtask

    task automatic run_layer(input string tag, input int finDelay, input int strayAt,
                             output int nWords, output logic [63:0] w0);
        logic [63:0] expW[$];
        logic [63:0] w;
        int n = layerX.size();
        int d0;
        int cyc;
        xv_t stray = '{300, 300, 300, 300};
        for (int i = 0; i < (n + NPW - 1) / NPW; i++) expW.push_back('0);
        for (int i = 0; i < n; i++) begin
            w = expW[i / NPW];
            w[(i % NPW) * T +: T] = lif_ref(layerX[i]);
            expW[i / NPW] = w;
        end
        gotData.delete();
        gotLast.delete();
        d0 = doneCnt;
        for (int i = 0; i < n; i++) drive_beat(layerX[i], (finDelay == 0) && (i == n - 1));
        if (finDelay > 0) begin
            repeat (finDelay - 1) step();
            i_Psum_Finish = 1'b1;
            step();
            i_Psum_Finish = 1'b0;
        end
        if (strayAt > 0) begin
            repeat (strayAt - 1) step();
            drive_beat(stray, 1'b0);
        end
        cyc = 0;
        while (doneCnt == d0 && cyc < 3000) begin
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, 64'(doneCnt != d0), 64'd1);
        repeat (4) step();
        check({tag, "_done_once"}, 64'(doneCnt - d0), 64'd1);
        check({tag, "_nwords"}, 64'(gotData.size()), 64'(expW.size()));
        for (int i = 0; i < gotData.size() && i < expW.size(); i++) begin
            check($sformatf("%s_w%0d_data", tag, i), gotData[i], expW[i]);
            check($sformatf("%s_w%0d_last", tag, i), 64'(gotLast[i]), 64'(i == expW.size() - 1));
        end
        nWords = gotData.size();
        w0 = (gotData.size() > 0) ? gotData[0] : '0;
    endtask

    initial begin
        int          nW;
        int          cyc;
        logic [63:0] w0;
        xv_t         v;
        xv_t         x512 = '{512, 512, 512, 512};

        vecs[0] = '{1,   512, 0, 0, 1, 4'b1111};
        vecs[1] = '{1,   300, 0, 0, 1, 4'b0100};
        vecs[2] = '{1, -1000, 0, 0, 1, 4'b0000};
        vecs[3] = '{40,  512, 0, 0, 3, 4'b1111};
        vecs[4] = '{32,  512, 0, 0, 2, 4'b1111};
        vecs[5] = '{17,  300, 2, 0, 2, 4'b0100};
        vecs[6] = '{1,   512, 0, 2, 1, 4'b1111};

        do_reset();
        check("rst_valid", 64'(o_spike_valid), 64'd0);
        check("rst_data", o_spike_data, 64'd0);
        check("rst_last", 64'(o_spike_last), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_overflow", 64'(o_overflow), 64'd0);
        s_rst_n = 1'b1;
        readyLevel = 1'b1;
        step();

        for (int k = 0; k < 7; k++) begin
            layerX.delete();
            for (int i = 0; i < vecs[k].n; i++) layerX.push_back('{vecs[k].x, vecs[k].x, vecs[k].x, vecs[k].x});
            run_layer($sformatf("vec%0d", k), vecs[k].finDelay, vecs[k].strayAt, nW, w0);
            check($sformatf("vec%0d_expwords", k), 64'(nW), 64'(vecs[k].expWords));
            check($sformatf("vec%0d_neuron0", k), 64'(w0[3:0]), 64'(vecs[k].expNib));
        end

        gotData.delete();
        i_Psum_Finish = 1'b1;
        for (int j = 0; j <= T + 3; j++) begin
            @(negedge s_clk);
            check($sformatf("zero_done_c%0d", j), 64'(o_done), 64'(j == T + 2));
            if (j == 0) begin
                @(posedge s_clk);
                #1;
                i_Psum_Finish = 1'b0;
            end
        end
        step();
        check("zero_no_word", 64'(gotData.size()), 64'd0);

        randReady = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 50);
            layerX.delete();
            for (int i = 0; i < n; i++) begin
                for (int t = 0; t < T; t++) v[t] = int'($urandom_range(0, 1700)) - 600;
                layerX.push_back(v);
            end
            run_layer($sformatf("rnd%0d", r), (n % NPW == 0) ? 0 : int'($urandom_range(0, 3)), 0, nW, w0);
        end
        randReady  = 1'b0;
        readyLevel = 1'b0;
        step();
        step();

        for (int i = 0; i < 100; i++) drive_beat(x512, 1'b0);
        repeat (10) step();
        check("ovf_flag", 64'(o_overflow), 64'd1);
        check("ovf_valid", 64'(o_spike_valid), 64'd1);
        gotData.delete();
        gotLast.delete();
        readyLevel = 1'b1;
        cyc = 0;
        step();
        while (o_spike_valid && cyc < 100) begin
            step();
            cyc++;
        end
        repeat (3) step();
        check("ovf_queued_words", 64'(gotData.size()), 64'd4);
        check("ovf_word0", (gotData.size() > 0) ? gotData[0] : '0, {64{1'b1}});
        check("ovf_sticky", 64'(o_overflow), 64'd1);

        readyLevel = 1'b0;
        step();
        for (int i = 0; i < 40; i++) drive_beat(x512, 1'b0);
        repeat (8) step();
        check("pre_rst_valid", 64'(o_spike_valid), 64'd1);
        #3;
        s_rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(o_spike_valid), 64'd0);
        check("async_rst_data", o_spike_data, 64'd0);
        check("async_rst_last", 64'(o_spike_last), 64'd0);
        check("async_rst_done", 64'(o_done), 64'd0);
        check("async_rst_overflow", 64'(o_overflow), 64'd0);
        repeat (2) step();
        s_rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_valid", 64'(o_spike_valid), 64'd0);
        check("post_rst_overflow", 64'(o_overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
